stack8_ctrl: RTL and testbench

STACK8_CTRL -- requirements
Module: stack8_ctrl

---
 rtl/stack8_ctrl.sv | 115 +++++++++++
 tb/tb_stack8_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack8_ctrl.sv
// 8 x 16-bit LIFO controller driving an external RAM8 with combinational read.
// A push or a pop takes two cycles (IDLE -> WR/RD -> IDLE). Errors are sticky until rst.
module stack8_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        dout_valid,
   output logic        busy,
   output logic        full,
   output logic        empty,
   output logic [3:0]  count,
   output logic        err,
   output logic [3:0]  ram_addr,
   output logic        ram_load,
   output logic [15:0] ram_inp,
   input  logic [15:0] ram_out
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;

   logic [1:0]  state_reg, state_next;
   logic [3:0]  sp_reg, sp_next;
   logic [15:0] data_q_reg, data_q_next;
   logic [15:0] dout_reg, dout_next;
   logic        dout_valid_reg, dout_valid_next;
   logic        err_reg, err_next;
   logic [2:0]  rd_slot;

   // Top-of-stack slot; only meaningful when sp is non-zero, i.e. in RD.
   assign rd_slot = sp_reg[2:0] - 3'd1;

   always_comb begin
      state_next      = state_reg;
      sp_next         = sp_reg;
      data_q_next     = data_q_reg;
      dout_next       = dout_reg;
      dout_valid_next = 1'b0;
      err_next        = err_reg;
      case (state_reg)
         IDLE: begin
            if (push && pop) begin
               err_next = 1'b1;
            end else if (push) begin
               if (sp_reg == 4'd8) begin
                  err_next = 1'b1;
               end else begin
                  data_q_next = din;
                  state_next  = WR;
               end
            end else if (pop) begin
               if (sp_reg == 4'd0) begin
                  err_next = 1'b1;
               end else begin
                  state_next = RD;
               end
            end
         end
         WR: begin
            sp_next    = sp_reg + 4'd1;
            state_next = IDLE;
         end
         RD: begin
            dout_next       = ram_out;
            dout_valid_next = 1'b1;
            sp_next         = sp_reg - 4'd1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         sp_reg         <= 4'd0;
         data_q_reg     <= 16'd0;
         dout_reg       <= 16'd0;
         dout_valid_reg <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sp_reg         <= sp_next;
         data_q_reg     <= data_q_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         err_reg        <= err_next;
      end
   end

   // RAM controls decode straight from state so an async reset kills ram_load at once.
   always_comb begin
      ram_addr = 4'd0;
      case (state_reg)
         WR:      ram_addr = {1'b0, sp_reg[2:0]};
         RD:      ram_addr = {1'b0, rd_slot};
         default: ram_addr = 4'd0;
      endcase
   end

   assign ram_load   = (state_reg == WR);
   assign ram_inp    = data_q_reg;
   assign dout       = dout_reg;
   assign dout_valid = dout_valid_reg;
   assign err        = err_reg;
   assign count      = sp_reg;
   assign full       = (sp_reg == 4'd8);
   assign empty      = (sp_reg == 4'd0);
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_stack8_ctrl.sv
// Self-checking bench for stack8_ctrl: directed scenarios plus random push/pop traffic
// compared every cycle against a queue-based stack model and a behavioural RAM8.
module tb_stack8_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        push, pop;
   logic [15:0] din;
   logic [15:0] dout;
   logic        dout_valid, busy, full, empty, err;
   logic [3:0]  count;
   logic [3:0]  ram_addr;
   logic        ram_load;
   logic [15:0] ram_inp;
   logic [15:0] ram_out;

   int checks = 0;
   int errors = 0;

   stack8_ctrl dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
      .dout(dout), .dout_valid(dout_valid), .busy(busy), .full(full),
      .empty(empty), .count(count), .err(err), .ram_addr(ram_addr),
      .ram_load(ram_load), .ram_inp(ram_inp), .ram_out(ram_out)
   );

   always #5 clk = ~clk;

   // RAM8: synchronous write, combinational read, never cleared by rst
   logic [15:0] ram_mem [0:7];
   initial for (int i = 0; i < 8; i++) ram_mem[i] = 16'h0;
   always @(posedge clk) if (ram_load) ram_mem[ram_addr[2:0]] <= ram_inp;
   assign ram_out = ram_mem[ram_addr[2:0]];

   // Reference model: a stack queue plus the operation currently in flight
   logic [15:0] stk[$];
   int          pend;        // 0 none, 1 push in flight, 2 pop in flight
   logic [15:0] pend_data;
   logic [15:0] last_data;
   logic [15:0] m_dout;
   logic        m_valid;
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      stk.delete();
      pend = 0; pend_data = 0; last_data = 0;
      m_dout = 0; m_valid = 0; m_err = 0;
   endtask

   task automatic model_edge(input logic p, input logic q, input logic [15:0] d);
      m_valid = 1'b0;
      if (pend == 1) begin
         stk.push_back(pend_data);
         pend = 0;
      end else if (pend == 2) begin
         m_dout  = stk.pop_back();
         m_valid = 1'b1;
         pend    = 0;
      end else if (p && q) begin
         m_err = 1'b1;
      end else if (p) begin
         if (stk.size() == 8) m_err = 1'b1;
         else begin pend = 1; pend_data = d; last_data = d; end
      end else if (q) begin
         if (stk.size() == 0) m_err = 1'b1;
         else pend = 2;
      end
   endtask

   task automatic check_outputs();
      int n;
      int exp_addr;
      n = stk.size();
      exp_addr = (pend == 1) ? n : (pend == 2) ? n - 1 : 0;
      check("count", 32'(count), 32'(n));
      check("full", 32'(full), 32'(n == 8));
      check("empty", 32'(empty), 32'(n == 0));
      check("busy", 32'(busy), 32'(pend != 0));
      check("err", 32'(err), 32'(m_err));
      check("dout", 32'(dout), 32'(m_dout));
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      check("ram_load", 32'(ram_load), 32'(pend == 1));
      check("ram_addr", 32'(ram_addr), 32'(exp_addr));
      check("ram_inp", 32'(ram_inp), 32'(last_data));
   endtask

   // Called at a negedge: drive, let one rising edge pass, check at the next negedge
   task automatic cycle(input logic p, input logic q, input logic [15:0] d);
      push = p; pop = q; din = d;
      @(posedge clk);
      model_edge(p, q, d);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_push(input logic [15:0] d);
      cycle(1'b1, 1'b0, d);
      cycle(1'b0, 1'b0, 16'h0);
      $display("push %h count=%0d err=%0b", d, count, err);
   endtask

   task automatic do_pop();
      cycle(1'b0, 1'b1, 16'h0);
      cycle(1'b0, 1'b0, 16'h0);
      $display("pop dout=%h valid=%0b count=%0d err=%0b", dout, dout_valid, count, err);
   endtask

   task automatic apply_reset();
      push = 0; pop = 0; din = 0;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ram_load", 32'(ram_load), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("reset released");
   endtask

   logic [15:0] saved0;

   initial begin
      push = 0; pop = 0; din = 0; rst = 1'b1;
      model_reset();
      @(negedge clk);
      apply_reset();
      check_outputs();

      // pop from empty after reset
      cycle(1'b0, 1'b1, 16'h0);
      cycle(1'b0, 1'b0, 16'h0);
      check("empty_pop_err", 32'(err), 32'd1);
      check("empty_pop_dout", 32'(dout), 32'd0);
      check("empty_pop_valid", 32'(dout_valid), 32'd0);

      // LIFO order
      apply_reset();
      do_push(16'h1111); do_push(16'h2222); do_push(16'h3333);
      do_pop(); check("lifo_1", 32'(dout), 32'h3333);
      do_pop(); check("lifo_2", 32'(dout), 32'h2222);
      do_pop(); check("lifo_3", 32'(dout), 32'h1111);
      check("lifo_count", 32'(count), 32'd0);

      // fill, overflow, then pop
      apply_reset();
      for (int i = 0; i < 8; i++) do_push(16'hA000 + 16'(i));
      check("fill_full", 32'(full), 32'd1);
      check("fill_count", 32'(count), 32'd8);
      do_push(16'hDEAD);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_count", 32'(count), 32'd8);
      do_pop(); check("ovf_pop", 32'(dout), 32'hA007);
      do_pop(); check("ovf_pop2", 32'(dout), 32'hA006);

      // simultaneous push and pop
      apply_reset();
      do_push(16'h0101); do_push(16'h0202);
      cycle(1'b1, 1'b1, 16'h0303);
      cycle(1'b0, 1'b0, 16'h0);
      check("conflict_err", 32'(err), 32'd1);
      check("conflict_count", 32'(count), 32'd2);

      // pop while busy with a push is ignored
      apply_reset();
      cycle(1'b1, 1'b0, 16'h4444);
      cycle(1'b0, 1'b1, 16'h0);
      cycle(1'b0, 1'b0, 16'h0);
      check("busy_pop_count", 32'(count), 32'd1);
      check("busy_pop_err", 32'(err), 32'd0);

      // reset in the middle of a write
      apply_reset();
      do_push(16'h1234);
      do_pop();
      saved0 = ram_mem[0];
      cycle(1'b1, 1'b0, 16'hBEEF);
      check("midwr_load", 32'(ram_load), 32'd1);
      push = 0;
      rst = 1'b1;
      #1;
      check("midwr_load_drop", 32'(ram_load), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check("midwr_ram", 32'(ram_mem[0]), 32'(saved0));
      check_outputs();
      do_push(16'h5A5A);
      do_pop();
      check("midwr_after", 32'(dout), 32'h5A5A);

      // random traffic, alternating push-heavy and pop-heavy phases
      apply_reset();
      for (int i = 0; i < 800; i++) begin
         logic p, q;
         if (((i / 100) % 2) == 0) begin
            p = ($urandom_range(0, 9) < 6);
            q = ($urandom_range(0, 9) < 3);
         end else begin
            p = ($urandom_range(0, 9) < 3);
            q = ($urandom_range(0, 9) < 6);
         end
         cycle(p, q, 16'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
